// File: rtl/usb_tx_packetizer.sv
// ---------------------------------------------------------------------------
// usb_tx_packetizer
//
// Builds one USB packet per accepted start request and feeds it byte by byte
// to a downstream serializer. A packet is either PID-only, or PID followed by
// a payload pulled from a first-word-fall-through FIFO and a CRC16 trailer
// that the serializer appends when told to.
//
// Ports
//   clk_48          in   48 MHz clock
//   rst_n           in   asynchronous active-low reset
//   start           in   single-cycle packet request (honoured only when idle)
//   pid[3:0]        in   PID nibble, sent as {~pid, pid}
//   with_data       in   1 = PID + payload + CRC16, 0 = PID only
//   len[9:0]        in   payload byte count, 0..1023
//   rd_data[7:0]    in   FIFO head byte (first-word-fall-through)
//   rd_empty        in   FIFO empty
//   rd_en           out  FIFO pop, combinational, one per payload byte loaded
//   tx_transmit     out  serializer: a packet byte is pending
//   tx_data[7:0]    out  serializer: byte to send
//   tx_update_crc16 out  serializer: fold tx_data into the running CRC16
//   tx_send_crc16   out  serializer: append CRC16 after the last byte
//   tx_data_strobe  in   serializer consumed tx_data this cycle
//   tx_en           in   serializer still busy on the line
//   busy            out  packet in progress
//   done            out  one-cycle pulse when the packet has left the line
//   underrun        out  one-cycle pulse when the FIFO ran dry mid-payload
// ---------------------------------------------------------------------------
module usb_tx_packetizer (
  input  logic       clk_48,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic       with_data,
  input  logic [9:0] len,
  input  logic [7:0] rd_data,
  input  logic       rd_empty,
  output logic       rd_en,
  output logic       tx_transmit,
  output logic [7:0] tx_data,
  output logic       tx_update_crc16,
  output logic       tx_send_crc16,
  input  logic       tx_data_strobe,
  input  logic       tx_en,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PID,
    S_PAYLOAD,
    S_TAIL
  } state_t;

  state_t     state;
  logic [9:0] remaining;    // payload bytes not yet loaded into tx_data
  logic       with_data_r;  // packet type captured at accept

  logic accept;
  logic in_tx;
  logic load_point;

  // A start landing on the done cycle is refused so a new packet never
  // overlaps the completion pulse of the previous one.
  // NOTE: every always_comb output is assigned on every path (here by
  // continuous expressions), so no latch can be inferred.
  always_comb begin
    accept     = (state == S_IDLE) && start && !tx_en && !done;
    in_tx      = (state == S_PID) || (state == S_PAYLOAD);
    load_point = in_tx && tx_data_strobe && with_data_r && (remaining != 10'd0);
    rd_en      = load_point && !rd_empty;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  // NOTE: all control state is reset; tx_data is cleared too so the
  // serializer never sees stale data after reset.
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      remaining       <= 10'd0;
      with_data_r     <= 1'b0;
      tx_transmit     <= 1'b0;
      tx_data         <= 8'h00;
      tx_update_crc16 <= 1'b0;
      tx_send_crc16   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      // Pulses default low and are raised for a single cycle below.
      done     <= 1'b0;
      underrun <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state           <= S_PID;
            remaining       <= len;
            with_data_r     <= with_data;
            tx_transmit     <= 1'b1;
            tx_data         <= {~pid, pid};
            tx_update_crc16 <= 1'b0;
            tx_send_crc16   <= 1'b0;
            busy            <= 1'b1;
          end
        end

        S_PID, S_PAYLOAD: begin
          if (tx_data_strobe) begin
            if (load_point && !rd_empty) begin
              // Serializer took the current byte; hand it the next payload byte.
              state           <= S_PAYLOAD;
              tx_data         <= rd_data;
              tx_update_crc16 <= 1'b1;
              remaining       <= remaining - 10'd1;
            end else if (load_point) begin
              // FIFO dry with bytes still owed: cut the packet short and
              // suppress the CRC so the receiver sees a corrupt packet.
              state         <= S_TAIL;
              tx_transmit   <= 1'b0;
              tx_send_crc16 <= 1'b0;
              underrun      <= 1'b1;
            end else begin
              // Last byte consumed (or PID-only packet): append CRC if data.
              state         <= S_TAIL;
              tx_transmit   <= 1'b0;
              tx_send_crc16 <= with_data_r;
            end
          end
        end

        S_TAIL: begin
          // Hold tx_send_crc16 until the serializer has drained the line.
          if (!tx_en) begin
            state           <= S_IDLE;
            tx_send_crc16   <= 1'b0;
            tx_update_crc16 <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// ---------------------------------------------------------------------------
// tb_usb_tx_packetizer
//
// Self-checking bench for usb_tx_packetizer. A serializer model strobes every
// 32 clocks while tx_transmit is high and holds tx_en until 3 bit-times
// (12 clocks) after transmit drops. A FWFT FIFO model supplies payload bytes.
// Expected packets are computed from the packet rules: byte list, CRC-update
// flags, pop count, underrun and CRC-send behaviour.
// ---------------------------------------------------------------------------
module tb_usb_tx_packetizer;

  logic       clk_48 = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] pid;
  logic       with_data;
  logic [9:0] len;
  logic [7:0] rd_data;
  logic       rd_empty;
  logic       rd_en;
  logic       tx_transmit;
  logic [7:0] tx_data;
  logic       tx_update_crc16;
  logic       tx_send_crc16;
  logic       tx_data_strobe;
  logic       tx_en;
  logic       busy;
  logic       done;
  logic       underrun;

  usb_tx_packetizer dut (
    .clk_48          (clk_48),
    .rst_n           (rst_n),
    .start           (start),
    .pid             (pid),
    .with_data       (with_data),
    .len             (len),
    .rd_data         (rd_data),
    .rd_empty        (rd_empty),
    .rd_en           (rd_en),
    .tx_transmit     (tx_transmit),
    .tx_data         (tx_data),
    .tx_update_crc16 (tx_update_crc16),
    .tx_send_crc16   (tx_send_crc16),
    .tx_data_strobe  (tx_data_strobe),
    .tx_en           (tx_en),
    .busy            (busy),
    .done            (done),
    .underrun        (underrun)
  );

  always #5 clk_48 = ~clk_48;

  int checks = 0;
  int errors = 0;

  // FIFO contents and monitor statistics
  logic [7:0] fifo[$];
  logic [7:0] cap_data[$];
  logic       cap_upd[$];
  int  pop_cnt, done_cnt, und_cnt, tail_cnt, send_cnt, stray_cnt;
  bit  pop_flag = 1'b0;
  int  ser_cnt = 0;
  int  hold = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serializer + FIFO driver: updates inputs on the falling edge.
  always @(negedge clk_48) begin
    if (!rst_n) begin
      ser_cnt        = 0;
      hold           = 0;
      tx_data_strobe = 1'b0;
      tx_en          = 1'b0;
    end else begin
      if (pop_flag && fifo.size() > 0) void'(fifo.pop_front());
      if (tx_transmit) begin
        tx_en = 1'b1;
        hold  = 12;
        ser_cnt++;
        if (ser_cnt == 32) begin
          tx_data_strobe = 1'b1;
          ser_cnt        = 0;
        end else begin
          tx_data_strobe = 1'b0;
        end
      end else begin
        tx_data_strobe = 1'b0;
        ser_cnt        = 0;
        if (hold > 0) begin
          hold--;
          if (hold == 0) tx_en = 1'b0;
        end
      end
    end
    rd_empty = (fifo.size() == 0);
    rd_data  = rd_empty ? 8'h00 : fifo[0];
  end

  // Monitor: samples settled outputs shortly after the falling edge.
  always @(negedge clk_48) begin
    #1;
    if (rst_n) begin
      if (tx_data_strobe) begin
        cap_data.push_back(tx_data);
        cap_upd.push_back(tx_update_crc16);
      end
      if (rd_en) begin
        pop_cnt++;
        if (!tx_data_strobe) stray_cnt++;
      end
      pop_flag = rd_en;
      if (done) done_cnt++;
      if (underrun) und_cnt++;
      if (busy && !tx_transmit) begin
        tail_cnt++;
        if (tx_send_crc16) send_cnt++;
      end
    end else begin
      pop_flag = 1'b0;
    end
  end

  task automatic clear_stats();
    cap_data.delete();
    cap_upd.delete();
    pop_cnt = 0; done_cnt = 0; und_cnt = 0;
    tail_cnt = 0; send_cnt = 0; stray_cnt = 0;
  endtask

  // Runs one packet using the bytes already queued in fifo and checks it
  // against the packet rules. poke issues a start while busy.
  task automatic run_packet(input string name, input logic [3:0] p, input logic wd,
                            input int n, input bit poke);
    logic [7:0] exp_data[$];
    logic       exp_upd[$];
    int fsize, npop, cyc, budget;
    bit und, send_exp;

    fsize    = fifo.size();
    npop     = wd ? ((n < fsize) ? n : fsize) : 0;
    und      = wd && (fsize < n);
    send_exp = wd && !und;
    exp_data.push_back({~p, p});
    exp_upd.push_back(1'b0);
    for (int i = 0; i < npop; i++) begin
      exp_data.push_back(fifo[i]);
      exp_upd.push_back(1'b1);
    end
    clear_stats();

    @(negedge clk_48);
    start = 1'b1; pid = p; with_data = wd; len = 10'(n);
    @(negedge clk_48);
    // Scramble the request fields: only the accept-cycle values matter.
    start = 1'b0; pid = 4'($urandom); with_data = 1'($urandom); len = 10'($urandom);
    #2;
    check({name, ".accept_busy"}, busy, 1);
    check({name, ".accept_transmit"}, tx_transmit, 1);
    check({name, ".accept_tx_data"}, tx_data, {~p, p});
    check({name, ".accept_update"}, tx_update_crc16, 0);

    if (poke) begin
      repeat (40) @(negedge clk_48);
      start = 1'b1; pid = ~p; with_data = ~wd; len = 10'd5;
      @(negedge clk_48);
      start = 1'b0;
    end

    budget = (n + 3) * 33 + 100;
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk_48);
      #2;
      cyc++;
    end
    check({name, ".done_seen"}, done, 1);

    // Start on the done cycle must be refused.
    start = 1'b1; pid = 4'h2; with_data = 1'b0; len = 10'd0;
    @(negedge clk_48);
    start = 1'b0;
    #2;
    check({name, ".start_at_done_ignored"}, busy, 0);
    repeat (3) @(negedge clk_48);
    #2;

    check({name, ".byte_count"}, cap_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
      check($sformatf("%s.byte%0d", name, i), cap_data[i], exp_data[i]);
      check($sformatf("%s.upd%0d", name, i), cap_upd[i], exp_upd[i]);
    end
    check({name, ".pops"}, pop_cnt, npop);
    check({name, ".stray_rd_en"}, stray_cnt, 0);
    check({name, ".underrun_pulses"}, und_cnt, und ? 1 : 0);
    check({name, ".done_pulses"}, done_cnt, 1);
    check({name, ".tail_seen"}, tail_cnt > 0, 1);
    check({name, ".send_crc16"}, send_cnt, send_exp ? tail_cnt : 0);
    check({name, ".fifo_left"}, fifo.size(), fsize - npop);
    fifo.delete();
  endtask

  initial begin
    int n, fs;
    int p0;
    rst_n = 1'b0; start = 1'b0; pid = 4'h0; with_data = 1'b0; len = 10'd0;
    tx_data_strobe = 1'b0; tx_en = 1'b0; rd_data = 8'h00; rd_empty = 1'b1;
    clear_stats();
    repeat (3) @(negedge clk_48);
    #2;
    check("reset.outputs",
          {rd_en, tx_transmit, tx_data, tx_update_crc16, tx_send_crc16, busy, done, underrun}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_48);

    // ACK
    run_packet("ack", 4'h2, 1'b0, 0, 1'b0);

    // DATA0 with 01,02,03, plus a start while busy
    fifo.push_back(8'h01); fifo.push_back(8'h02); fifo.push_back(8'h03);
    run_packet("data0", 4'h3, 1'b1, 3, 1'b1);

    // Zero-length DATA1
    run_packet("zlp", 4'hB, 1'b1, 0, 1'b0);

    // Underrun: 4 bytes requested, 2 available
    fifo.push_back(8'hA5); fifo.push_back(8'h5A);
    run_packet("underrun", 4'h3, 1'b1, 4, 1'b0);

    // Randomized packets
    for (int k = 0; k < 6; k++) begin
      n  = $urandom_range(0, 12);
      fs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : n;
      for (int i = 0; i < fs; i++) fifo.push_back(8'($urandom));
      run_packet($sformatf("rand%0d", k), 4'($urandom), 1'($urandom), n, 1'($urandom));
    end

    // Maximum length
    for (int i = 0; i < 1023; i++) fifo.push_back(8'($urandom));
    run_packet("max_len", 4'h3, 1'b1, 1023, 1'b0);

    // Reset in the middle of a payload
    for (int i = 0; i < 20; i++) fifo.push_back(8'($urandom));
    clear_stats();
    @(negedge clk_48);
    start = 1'b1; pid = 4'hC; with_data = 1'b1; len = 10'd20;
    @(negedge clk_48);
    start = 1'b0;
    repeat (136) @(negedge clk_48);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset.outputs",
          {rd_en, tx_transmit, tx_data, tx_update_crc16, tx_send_crc16, busy, done, underrun}, 0);
    check("midreset.had_pops", pop_cnt > 0, 1);
    p0 = pop_cnt;
    repeat (5) @(negedge clk_48);
    rst_n = 1'b1;
    repeat (300) @(negedge clk_48);
    #2;
    check("midreset.no_more_pops", pop_cnt, p0);
    check("midreset.no_done", done_cnt, 0);
    check("midreset.idle", busy, 0);
    fifo.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
